// File: rtl/mem_stage_sram_ctrl.sv
// ============================================================================
// mem_stage_sram_ctrl : MEM-stage controller for a fixed-latency 32-bit SRAM
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_stage_sram_ctrl #(
    parameter int          WAIT_CYCLES = 5,
    parameter int          ADDR_W      = 16,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_Res,
    input  logic [31:0]       Val_Rm,
    output logic              ready,
    output logic [31:0]       MEM_Result,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [31:0]       SRAM_WDATA,
    input  logic [31:0]       SRAM_RDATA,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op_write;
    logic [31:0]        r_result;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_we_n;
    logic               r_oe_n;

    logic               w_req;
    logic [31:0]        w_offset;
    logic               w_unused_bits;

    assign w_req         = MEM_R_EN | MEM_W_EN;
    assign w_offset      = ALU_Res - BASE_ADDR;
    // Only the word-address slice is forwarded; the rest is intentionally dropped.
    assign w_unused_bits = ^w_offset;

    assign ready      = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);
    assign MEM_Result = r_result;
    assign SRAM_ADDR  = r_addr;
    assign SRAM_WDATA = r_wdata;
    assign SRAM_WE_N  = r_we_n;
    assign SRAM_OE_N  = r_oe_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = ST_BUSY;
            ST_BUSY: if (r_cnt == '0) w_next = ST_DONE;
            // DONE never re-arms directly; the held request must not fire twice.
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // SRAM strobes are registered so they are glitch-free for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_op_write <= 1'b0;
            r_result   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we_n     <= 1'b1;
            r_oe_n     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr     <= w_offset[ADDR_W+1:2];
                        r_wdata    <= Val_Rm;
                        r_op_write <= MEM_W_EN;
                        r_cnt      <= CNT_INIT;
                        r_we_n     <= !MEM_W_EN;
                        r_oe_n     <= MEM_W_EN;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_we_n <= 1'b1;
                        r_oe_n <= 1'b1;
                        if (!r_op_write) begin
                            r_result <= SRAM_RDATA;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
// ============================================================================
// tb_mem_stage_sram_ctrl : self-checking bench with a latency-aware SRAM model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_sram_ctrl;

    localparam int W = 5;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] Val_Rm;
    logic        ready;
    logic [31:0] MEM_Result;
    logic [15:0] SRAM_ADDR;
    logic [31:0] SRAM_WDATA;
    logic [31:0] SRAM_RDATA;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;

    int errors = 0;
    int checks = 0;

    mem_stage_sram_ctrl #(
        .WAIT_CYCLES (W),
        .ADDR_W      (16),
        .BASE_ADDR   (32'd1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ALU_Res    (ALU_Res),
        .Val_Rm     (Val_Rm),
        .ready      (ready),
        .MEM_Result (MEM_Result),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WDATA (SRAM_WDATA),
        .SRAM_RDATA (SRAM_RDATA),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: read data is only valid after OE_N has been low for W cycles.
    logic [31:0] mem [16];
    int          oe_cnt  = 0;
    int          wr_cnt  = 0;
    int          rd_cnt  = 0;
    logic        prev_we = 1'b1;
    logic        prev_oe = 1'b1;

    assign SRAM_RDATA = (!SRAM_OE_N && oe_cnt >= W - 1) ? mem[SRAM_ADDR[3:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h1111_1111;
            mem[1]  <= 32'h2222_2222;
            mem[15] <= 32'hF0F0_F0F0;
        end else if (!SRAM_WE_N) begin
            mem[SRAM_ADDR[3:0]] <= SRAM_WDATA;
        end
        oe_cnt  <= SRAM_OE_N ? 0 : oe_cnt + 1;
        if (!SRAM_WE_N && prev_we) wr_cnt <= wr_cnt + 1;
        if (!SRAM_OE_N && prev_oe) rd_cnt <= rd_cnt + 1;
        prev_we <= SRAM_WE_N;
        prev_oe <= SRAM_OE_N;
    end

    typedef struct {
        logic        r_en;
        logic        w_en;
        logic [31:0] alu;
        logic [31:0] val;
        logic [15:0] exp_addr;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access held through DONE, then released in the following IDLE cycle.
    task automatic do_access(input int idx);
        int wr0;
        int rd0;
        logic wr;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        wr  = vecs[idx].w_en;
        MEM_R_EN = vecs[idx].r_en;
        MEM_W_EN = vecs[idx].w_en;
        ALU_Res  = vecs[idx].alu;
        Val_Rm   = vecs[idx].val;
        #1;
        check($sformatf("v%0d c0 ready", idx), {31'b0, ready}, 32'd0);
        check($sformatf("v%0d c0 strobes", idx), {30'b0, SRAM_WE_N, SRAM_OE_N}, 32'd3);
        for (int c = 1; c <= W; c++) begin
            tick();
            check($sformatf("v%0d c%0d ready", idx, c), {31'b0, ready}, 32'd0);
            check($sformatf("v%0d c%0d we_n/oe_n", idx, c), {30'b0, SRAM_WE_N, SRAM_OE_N},
                  {30'b0, !wr, wr});
            check($sformatf("v%0d c%0d addr", idx, c), {16'b0, SRAM_ADDR}, {16'b0, vecs[idx].exp_addr});
            check($sformatf("v%0d c%0d wdata", idx, c), SRAM_WDATA, vecs[idx].val);
        end
        tick();
        check($sformatf("v%0d done ready", idx), {31'b0, ready}, 32'd1);
        check($sformatf("v%0d done strobes", idx), {30'b0, SRAM_WE_N, SRAM_OE_N}, 32'd3);
        check($sformatf("v%0d result", idx), MEM_Result, vecs[idx].exp_result);
        check($sformatf("v%0d access count", idx), wr ? wr_cnt - wr0 : rd_cnt - rd0, 32'd1);
        check($sformatf("v%0d other count", idx), wr ? rd_cnt - rd0 : wr_cnt - wr0, 32'd0);
        tick();
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    initial begin
        int hi;
        int rd0;
        vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 16'd2,      32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h1234_5678, 16'd2,      32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 32'd1027, 32'h0000_0000, 16'd0,      32'h1111_1111};
        vecs[3] = '{1'b1, 1'b1, 32'd1036, 32'hCAFE_F00D, 16'd3,      32'h1111_1111};
        vecs[4] = '{1'b1, 1'b0, 32'd1036, 32'h0000_0001, 16'd3,      32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'h0000_0002, 16'hFFFF,   32'hF0F0_F0F0};

        // Reset held for two cycles with a store request pending.
        rst      = 1'b1;
        MEM_R_EN = vecs[0].r_en;
        MEM_W_EN = vecs[0].w_en;
        ALU_Res  = vecs[0].alu;
        Val_Rm   = vecs[0].val;
        tick();
        tick();
        check("rst result", MEM_Result, 32'd0);
        check("rst strobes", {30'b0, SRAM_WE_N, SRAM_OE_N}, 32'd3);
        check("rst addr", {16'b0, SRAM_ADDR}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) do_access(i);

        // Back-to-back loads: word 0 held through DONE, then word 1.
        rd0 = rd_cnt;
        hi  = 0;
        MEM_R_EN = 1'b1;
        ALU_Res  = 32'd1024;
        for (int c = 0; c <= W + 1; c++) begin
            #1;
            if (ready) hi++;
            if (c == 1) check("b2b first addr", {16'b0, SRAM_ADDR}, 32'd0);
            if (c == W + 1) check("b2b first result", MEM_Result, 32'h1111_1111);
            tick();
        end
        ALU_Res = 32'd1028;
        for (int c = 0; c <= W + 1; c++) begin
            #1;
            if (ready) hi++;
            if (c == 0) check("b2b no reissue", {31'b0, SRAM_OE_N}, 32'd1);
            if (c == 1) check("b2b second addr", {16'b0, SRAM_ADDR}, 32'd1);
            if (c == W + 1) check("b2b second result", MEM_Result, 32'h2222_2222);
            tick();
        end
        MEM_R_EN = 1'b0;
        #1;
        check("b2b ready pulses", hi, 32'd2);
        check("b2b read count", rd_cnt - rd0, 32'd2);

        // Abort a store in BUSY cycle 3.
        tick();
        MEM_W_EN = 1'b1;
        ALU_Res  = 32'd1040;
        Val_Rm   = 32'h0BAD_F00D;
        for (int c = 0; c < 3; c++) tick();
        check("abort busy we_n", {31'b0, SRAM_WE_N}, 32'd0);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        MEM_W_EN = 1'b0;
        #1;
        check("abort strobes", {30'b0, SRAM_WE_N, SRAM_OE_N}, 32'd3);
        check("abort addr", {16'b0, SRAM_ADDR}, 32'd0);
        check("abort result", MEM_Result, 32'd0);
        check("abort ready", {31'b0, ready}, 32'd1);

        // Ten idle cycles.
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("idle c%0d", c), {29'b0, ready, SRAM_WE_N, SRAM_OE_N}, 32'd7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
